// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-side signal bundle for mux_sel_sequencer.
// master: scan requester + mux; slave: the sequencer itself.
//
// Ports (slave view):
//   start, en_mask[3:0], continuous  in   scan control
//   y                                in   mux_4x1 output
//   s1, s2                           out  mux selects (MSB, LSB)
//   busy, done                       out  scan status
//   sample[3:0], sample_valid        out  captured word
interface mux_sel_sequencer_if;
    logic       start;
    logic [3:0] en_mask;
    logic       continuous;
    logic       y;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic       sample_valid;

    modport master (
        output start,
        output en_mask,
        output continuous,
        output y,
        input  s1,
        input  s2,
        input  busy,
        input  done,
        input  sample,
        input  sample_valid
    );

    modport slave (
        input  start,
        input  en_mask,
        input  continuous,
        input  y,
        output s1,
        output s2,
        output busy,
        output done,
        output sample,
        output sample_valid
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Scans the enabled mux_4x1 channels in ascending order, dwelling DWELL
// cycles on each, and packs the captured y bits into a sample word.
//
// Parameters: DWELL (1..255) cycles per channel; CW counter width.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of mux_sel_sequencer_if (start/en_mask/continuous/y
//        in; s1/s2/busy/done/sample/sample_valid out)
module mux_sel_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DWELL  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t        state, state_n;
    logic [1:0]    ch, ch_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    mask, mask_n;
    logic [3:0]    shadow, shadow_n;
    logic [3:0]    sample, sample_n;
    logic [2:0]    nxt;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        return r;
    endfunction

    // {found, index} of the lowest enabled channel above c.
    function automatic logic [2:0] next_ch(
        input logic [3:0] m,
        input logic [1:0] c
    );
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(c) && m[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ch     <= 2'd0;
            cnt    <= '0;
            mask   <= 4'd0;
            shadow <= 4'd0;
            sample <= 4'd0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            cnt    <= cnt_n;
            mask   <= mask_n;
            shadow <= shadow_n;
            sample <= sample_n;
        end
    end

    assign nxt = next_ch(mask, ch);

    always_comb begin
        state_n  = state;
        ch_n     = ch;
        cnt_n    = cnt;
        mask_n   = mask;
        shadow_n = shadow;
        sample_n = sample;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mask_n = bus.en_mask;
                    if (bus.en_mask != 4'd0) begin
                        shadow_n = 4'd0;
                        ch_n     = lowest(bus.en_mask);
                        cnt_n    = RELOAD;
                        state_n  = S_DWELL;
                    end else begin
                        // Empty scan: report done, keep sample.
                        ch_n    = 2'd0;
                        state_n = S_FINISH;
                    end
                end
            end
            S_DWELL: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shadow_n[ch] = bus.y;
                    if (nxt[2]) begin
                        ch_n  = nxt[1:0];
                        cnt_n = RELOAD;
                    end else begin
                        sample_n = shadow_n;
                        state_n  = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                if (bus.continuous && mask != 4'd0) begin
                    shadow_n = 4'd0;
                    ch_n     = lowest(mask);
                    cnt_n    = RELOAD;
                    state_n  = S_DWELL;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Select is parked at 00 in IDLE; FINISH keeps the last channel.
    assign bus.s1           = (state != S_IDLE) & ch[1];
    assign bus.s2           = (state != S_IDLE) & ch[0];
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_FINISH);
    assign bus.sample_valid = (state == S_FINISH) && (mask != 4'd0);
    assign bus.sample       = sample;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized check of mux_sel_sequencer (DWELL=4 and DWELL=1 builds)
// against a queue-based scan-plan reference model.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] en_mask = 4'd0;
    logic       continuous = 1'b0;
    logic [3:0] data = 4'b1101;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] smp [2];
    logic       bsy [2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 1;

        mux_sel_sequencer_if ifc ();

        assign ifc.start      = start;
        assign ifc.en_mask    = en_mask;
        assign ifc.continuous = continuous;
        assign ifc.y          = data[{ifc.s1, ifc.s2}];
        assign smp[g]         = ifc.sample;
        assign bsy[g]         = ifc.busy;

        mux_sel_sequencer #(.DWELL(D), .CW(8)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );

        // Plan entries: ch (+8 on the capture cycle), 4 = finish.
        int         plan [$];
        int         cur = -1;
        int         last_ch = 0;
        logic [3:0] mm = 4'd0;
        logic [3:0] acc = 4'd0;
        logic [3:0] es = 4'd0;
        logic       arm;
        logic [3:0] am;

        always @(posedge clk) begin
            if (rst) begin
                plan.delete();
                cur = -1;
                mm = 4'd0;
                acc = 4'd0;
                es = 4'd0;
                last_ch = 0;
            end else begin
                arm = 1'b0;
                am = 4'd0;
                if (cur >= 8) acc[cur-8] = data[cur-8];
                if (cur == 4 && continuous && mm != 4'd0) begin
                    arm = 1'b1;
                    am = mm;
                end
                if (cur == -1 && start) begin
                    arm = 1'b1;
                    am = en_mask;
                    mm = en_mask;
                    last_ch = 0;
                end
                if (arm) begin
                    acc = 4'd0;
                    for (int c = 0; c < 4; c++)
                        if (am[c])
                            for (int k = 0; k < D; k++)
                                plan.push_back(c + ((k == D - 1) ? 8 : 0));
                    plan.push_back(4);
                end
                cur = (plan.size() != 0) ? plan.pop_front() : -1;
                if (cur >= 0 && cur != 4) last_ch = cur & 3;
                if (cur == 4 && mm != 4'd0) es = acc;
            end
        end

        always @(negedge clk) begin
            int esel;
            esel = (cur == -1) ? 0 : (cur == 4) ? last_ch : (cur & 3);
            chk($sformatf("d%0d.sel", D), {ifc.s1, ifc.s2}, esel);
            chk($sformatf("d%0d.busy", D), ifc.busy, cur != -1);
            chk($sformatf("d%0d.done", D), ifc.done, cur == 4);
            chk($sformatf("d%0d.valid", D), ifc.sample_valid,
                cur == 4 && mm != 4'd0);
            chk($sformatf("d%0d.sample", D), ifc.sample, es);
        end
    end

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        start = 1'b1;
        en_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(3);
        chk("rst.sample0", smp[0], 4'd0);
        chk("rst.busy0", bsy[0], 1'b0);
        rst = 1'b0;

        data = 4'b1101;
        pulse_start(4'b1111);
        wait_n(20);
        chk("full.sample0", smp[0], 4'b1101);
        chk("full.sample1", smp[1], 4'b1101);

        pulse_start(4'b0101);
        wait_n(12);
        chk("sparse.sample0", smp[0], 4'b0101);
        chk("sparse.sample1", smp[1], 4'b0101);

        pulse_start(4'b1111);
        wait_n(20);
        pulse_start(4'b0000);
        wait_n(3);
        chk("empty.sample0", smp[0], 4'b1101);
        chk("empty.sample1", smp[1], 4'b1101);

        continuous = 1'b1;
        pulse_start(4'b1111);
        wait_n(2);
        data[3] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            en_mask = 4'($urandom);
        end
        start = 1'b0;
        continuous = 1'b0;
        wait_n(20);
        chk("cont.sample0", smp[0], 4'b0101);
        chk("cont.sample1", smp[1], 4'b0101);

        data = 4'b1101;
        pulse_start(4'b1111);
        wait_n(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.sample0", smp[0], 4'd0);
        chk("midrst.busy0", bsy[0], 1'b0);
        wait_n(20);
        chk("midrst.idle0", bsy[0], 1'b0);
        pulse_start(4'b1111);
        wait_n(20);
        chk("rerun.sample0", smp[0], 4'b1101);
        chk("rerun.sample1", smp[1], 4'b1101);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            en_mask = 4'($urandom);
            continuous = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) data = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        wait_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
